// File: rtl/spi_master.sv
// spi_master: word-level SPI master, one WIDTH-bit word per tx handshake, received word on rx valid/ready port
// ports: clk/rst_n (sync, active-low); i_tx_* / o_tx_ready word in; o_rx_* / i_rx_ready word out; o_busy; o_spi_* / i_spi_miso bus
module spi_master #(
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int FSB     = 1,
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tx_valid,
  output logic             o_tx_ready,
  input  logic [WIDTH-1:0] i_tx_data,
  output logic             o_rx_valid,
  input  logic             i_rx_ready,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_busy,
  output logic             o_spi_sclk,
  output logic             o_spi_ss_n,
  output logic             o_spi_mosi,
  input  logic             i_spi_miso
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(WIDTH);
  localparam int EW = IW + 1;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  logic [2:0]       r_state;
  logic [DW-1:0]    r_div;
  logic [EW-1:0]    r_edge;
  logic [WIDTH-1:0] r_tx;
  logic [WIDTH-1:0] r_rx;
  logic             w_tick;
  logic             w_lead;
  logic             w_last;
  logic             w_smp;
  logic             w_drv;
  logic [IW-1:0]    w_sidx;
  logic [IW-1:0]    w_didx;
  logic [IW-1:0]    w_spos;
  logic [IW-1:0]    w_dpos;
  assign o_busy     = r_state != S_IDLE;
  assign o_tx_ready = (r_state == S_IDLE) && !o_rx_valid;
  assign w_tick     = r_div == DW'(CLK_DIV - 1);
  assign w_lead     = !r_edge[0];
  assign w_last     = r_edge == EW'(2 * WIDTH - 1);
  // wire-order bit index: sampling uses e/2; CPHA=0 drives the next bit on the trailing edge
  assign w_sidx     = r_edge[EW-1:1];
  assign w_didx     = (CPHA != 0) ? w_sidx : w_sidx + IW'(1);
  assign w_spos     = (FSB != 0) ? IW'(WIDTH - 1) - w_sidx : w_sidx;
  assign w_dpos     = (FSB != 0) ? IW'(WIDTH - 1) - w_didx : w_didx;
  assign w_smp      = (r_state == S_XFER) && w_tick && (w_lead ^ (CPHA != 0));
  assign w_drv      = (r_state == S_XFER) && w_tick && ((CPHA != 0) ? w_lead : !w_lead && !w_last);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_edge     <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_spi_sclk <= 1'(CPOL);
      o_spi_ss_n <= 1'b1;
      o_spi_mosi <= 1'b0;
    end else begin
      if (o_rx_valid && i_rx_ready) o_rx_valid <= 1'b0;
      r_div <= (r_state == S_IDLE || w_tick) ? '0 : r_div + DW'(1);
      if (w_smp) r_rx[w_spos] <= i_spi_miso;
      if (w_drv) o_spi_mosi <= r_tx[w_dpos];
      case (r_state)
        S_IDLE: if (i_tx_valid && o_tx_ready) begin
          r_tx       <= i_tx_data;
          o_spi_ss_n <= 1'b0;
          o_spi_mosi <= (FSB != 0) ? i_tx_data[WIDTH-1] : i_tx_data[0];
          r_state    <= S_SETUP;
        end
        S_SETUP: if (w_tick) begin
          r_edge  <= '0;
          r_state <= S_XFER;
        end
        S_XFER: if (w_tick) begin
          o_spi_sclk <= !o_spi_sclk;
          r_edge     <= w_last ? '0 : r_edge + EW'(1);
          if (w_last) r_state <= S_HOLD;
        end
        S_HOLD: if (w_tick) begin
          o_spi_ss_n <= 1'b1;
          o_rx_data  <= r_rx;
          o_rx_valid <= 1'b1;
          r_state    <= S_GAP;
        end
        S_GAP: if (w_tick) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: three spi_master configurations checked every cycle against a timing/bit-order model
module tb_spi_master;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  logic [2:0] txv = '0, rxr = '1, txr, rxv, bsy, sclk, ssn, mosi;
  logic [15:0] txd[3];
  logic [7:0] rxd0, rxd1;
  logic [15:0] rxd2;
  logic miso1;
  logic [15:0] mso1 = '0;
  int k[3];
  logic [15:0] mw[3], ms[3], ed[3];
  logic [2:0] ev;
  bit chk_en = 0;
  int total = 0, pass = 0;
  spi_master #(.CPOL(0), .CPHA(0), .FSB(1), .WIDTH(8), .CLK_DIV(4)) u0 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(txv[0]), .o_tx_ready(txr[0]), .i_tx_data(txd[0][7:0]),
    .o_rx_valid(rxv[0]), .i_rx_ready(rxr[0]), .o_rx_data(rxd0), .o_busy(bsy[0]),
    .o_spi_sclk(sclk[0]), .o_spi_ss_n(ssn[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(mosi[0]));
  spi_master #(.CPOL(1), .CPHA(1), .FSB(0), .WIDTH(8), .CLK_DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(txv[1]), .o_tx_ready(txr[1]), .i_tx_data(txd[1][7:0]),
    .o_rx_valid(rxv[1]), .i_rx_ready(rxr[1]), .o_rx_data(rxd1), .o_busy(bsy[1]),
    .o_spi_sclk(sclk[1]), .o_spi_ss_n(ssn[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso1));
  spi_master #(.CPOL(0), .CPHA(0), .FSB(1), .WIDTH(16), .CLK_DIV(2)) u2 (
    .clk(clk), .rst_n(rst_n), .i_tx_valid(txv[2]), .o_tx_ready(txr[2]), .i_tx_data(txd[2]),
    .o_rx_valid(rxv[2]), .i_rx_ready(rxr[2]), .o_rx_data(rxd2), .o_busy(bsy[2]),
    .o_spi_sclk(sclk[2]), .o_spi_ss_n(ssn[2]), .o_spi_mosi(mosi[2]), .i_spi_miso(mosi[2]));
  function automatic int wd(int i);
    return (i == 2) ? 16 : 8;
  endfunction
  function automatic int cd(int i);
    return (i == 0) ? 4 : ((i == 1) ? 3 : 2);
  endfunction
  function automatic logic cpol(int i);
    return i == 1;
  endfunction
  function automatic logic [15:0] mask(int i);
    return (i == 2) ? 16'hFFFF : 16'h00FF;
  endfunction
  function automatic logic [15:0] rx_of(int i);
    return (i == 0) ? {8'h0, rxd0} : ((i == 1) ? {8'h0, rxd1} : rxd2);
  endfunction
  // SCLK edges completed by cycle kk (kk = 1 is the first cycle after the handshake)
  function automatic int edges(int i, int kk);
    int h;
    if (kk < 1) return 0;
    h = (kk - 1) / cd(i);
    if (h < 1) return 0;
    return (h - 1 > 2 * wd(i)) ? 2 * wd(i) : h - 1;
  endfunction
  // wire-order index of the bit on the data lines after that many edges
  function automatic int jidx(int i, int kk);
    int d, j;
    d = edges(i, kk);
    j = (i == 1) ? ((d == 0) ? 0 : (d - 1) / 2) : d / 2;
    return (j > wd(i) - 1) ? wd(i) - 1 : j;
  endfunction
  function automatic logic wbit(int i, logic [15:0] w, int j);
    return (i != 1) ? w[wd(i)-1-j] : w[j];
  endfunction
  function automatic logic e_sclk(int i, int kk);
    return cpol(i) ^ (edges(i, kk) % 2 != 0);
  endfunction
  function automatic logic e_mosi(int i, int kk);
    return (kk == 0) ? 1'b0 : wbit(i, mw[i], jidx(i, kk));
  endfunction
  function automatic logic e_ssn(int i, int kk);
    return !(kk >= 1 && kk <= (2 * wd(i) + 2) * cd(i));
  endfunction
  function automatic logic e_busy(int i, int kk);
    return kk >= 1 && kk <= (2 * wd(i) + 3) * cd(i);
  endfunction
  function automatic logic e_txr(int i);
    return !e_busy(i, k[i]) && !ev[i];
  endfunction
  function automatic void chk(string nm, int i, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s dut%0d: got %0h expected %0h", nm, i, a, e);
  endfunction
  always_comb miso1 = (k[1] == 0) ? 1'b0 : wbit(1, ms[1], jidx(1, k[1]));
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        k[i]  <= 0;
        ev[i] <= 1'b0;
        ed[i] <= '0;
      end else begin
        if (txv[i] && e_txr(i)) begin
          k[i]  <= 1;
          mw[i] <= txd[i] & mask(i);
          ms[i] <= ((i == 1) ? mso1 : txd[i]) & mask(i);
        end else if (k[i] != 0 && k[i] < 1000000) k[i] <= k[i] + 1;
        if (k[i] == (2 * wd(i) + 2) * cd(i)) begin
          ev[i] <= 1'b1;
          ed[i] <= ms[i];
        end else if (ev[i] && rxr[i]) ev[i] <= 1'b0;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("sclk", i, 32'(sclk[i]), 32'(e_sclk(i, k[i])));
        chk("ss_n", i, 32'(ssn[i]), 32'(e_ssn(i, k[i])));
        chk("mosi", i, 32'(mosi[i]), 32'(e_mosi(i, k[i])));
        chk("busy", i, 32'(bsy[i]), 32'(e_busy(i, k[i])));
        chk("tx_ready", i, 32'(txr[i]), 32'(e_txr(i)));
        chk("rx_valid", i, 32'(rxv[i]), 32'(ev[i]));
        chk("rx_data", i, 32'(rx_of(i)), 32'(ed[i]));
      end
    end
  end
  task automatic xfer(input int i, input logic [15:0] w, input logic [15:0] m,
                      output int lat, output int pulses, output logic [15:0] bits, output int ssl);
    int n;
    logic prev;
    mso1 = m;
    txd[i] = w;
    txv[i] = 1'b1;
    n = 0;
    while (k[i] != 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", i, 32'(k[i] == 1), 32'd1);
    txv[i] = 1'b0;
    txd[i] = 16'($urandom);
    lat = 1;
    pulses = 0;
    bits = '0;
    ssl = 0;
    prev = sclk[i];
    while (!rxv[i] && lat < 3000) begin
      if (!ssn[i]) ssl++;
      if (sclk[i] && !prev) begin
        pulses++;
        bits = {bits[14:0], mosi[i]};
      end
      prev = sclk[i];
      @(negedge clk);
      lat++;
    end
    chk("rx_wait", i, 32'(rxv[i]), 32'd1);
  endtask
  initial begin
    int lat, pulses, ssl, n;
    logic [15:0] bits, w, m;
    logic prev;
    for (int i = 0; i < 3; i++) txd[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_sclk0", 0, 32'(sclk[0]), 32'd0);
    chk("rst_sclk1", 1, 32'(sclk[1]), 32'd1);
    chk("rst_ss_n", 0, 32'(ssn[0]), 32'd1);
    chk("rst_rx_valid", 0, 32'(rxv[0]), 32'd0);
    rst_n = 1;
    @(negedge clk);
    chk("idle_ready", 0, 32'(txr[0]), 32'd1);
    xfer(0, 16'h00A5, 16'h0, lat, pulses, bits, ssl);
    chk("a5_latency", 0, lat, 73);
    chk("a5_pulses", 0, pulses, 8);
    chk("a5_mosi", 0, 32'(bits), 32'h00A5);
    chk("a5_ss_low", 0, ssl, 72);
    chk("a5_rx", 0, 32'(rx_of(0)), 32'h00A5);
    xfer(1, 16'h003C, 16'h0096, lat, pulses, bits, ssl);
    chk("3c_latency", 1, lat, 55);
    chk("3c_mosi_lsb_first", 1, 32'(bits), 32'h003C);
    chk("3c_rx", 1, 32'(rx_of(1)), 32'h0096);
    xfer(2, 16'hBEEF, 16'h0, lat, pulses, bits, ssl);
    chk("beef_latency", 2, lat, 69);
    chk("beef_pulses", 2, pulses, 16);
    chk("beef_ss_low", 2, ssl, 68);
    chk("beef_mosi", 2, 32'(bits), 32'hBEEF);
    chk("beef_rx", 2, 32'(rx_of(2)), 32'hBEEF);
    repeat (10) @(negedge clk);
    rxr[0] = 1'b0;
    xfer(0, 16'h0011, 16'h0, lat, pulses, bits, ssl);
    txd[0] = 16'h0022;
    txv[0] = 1'b1;
    repeat (60) @(negedge clk);
    chk("bp_tx_ready", 0, 32'(txr[0]), 32'd0);
    chk("bp_rx_held", 0, 32'(rx_of(0)), 32'h0011);
    chk("bp_rx_valid", 0, 32'(rxv[0]), 32'd1);
    rxr[0] = 1'b1;
    xfer(0, 16'h0022, 16'h0, lat, pulses, bits, ssl);
    chk("bp_second", 0, 32'(rx_of(0)), 32'h0022);
    repeat (20) @(negedge clk);
    mso1 = 16'h0055;
    txd[1] = 16'h00AA;
    txv[1] = 1'b1;
    n = 0;
    while (k[1] != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    txv[1] = 1'b0;
    n = 0;
    prev = sclk[1];
    while (n < 3 && k[1] < 200) begin
      @(negedge clk);
      if (sclk[1] != prev) n++;
      prev = sclk[1];
    end
    chk("mid_edges", 1, n, 3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ss_n", 1, 32'(ssn[1]), 32'd1);
    chk("mid_rst_sclk", 1, 32'(sclk[1]), 32'd1);
    chk("mid_rst_rx_valid", 1, 32'(rxv[1]), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1, 16'h00F0, 16'h00F0, lat, pulses, bits, ssl);
    chk("after_rst_mosi", 1, 32'(bits), 32'h000F);
    chk("after_rst_rx", 1, 32'(rx_of(1)), 32'h00F0);
    repeat (20) @(negedge clk);
    txd[0] = 16'h005A;
    txv[0] = 1'b1;
    n = 0;
    while (k[0] != 1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (k[0] != 1 && n < 500);
    chk("b2b_period", 0, n, 77);
    txv[0] = 1'b0;
    repeat (100) @(negedge clk);
    for (int t = 0; t < 24; t++) begin
      int i;
      i = $urandom_range(0, 2);
      w = 16'($urandom) & mask(i);
      m = 16'($urandom) & mask(i);
      rxr[i] = 1'($urandom_range(0, 1));
      xfer(i, w, m, lat, pulses, bits, ssl);
      chk("rand_rx", i, 32'(rx_of(i)), 32'((i == 1) ? m : w));
      repeat ($urandom_range(0, 6)) @(negedge clk);
      rxr[i] = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (120) @(negedge clk);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Word-level SPI master that drives the bus consumed by the team's SPI slave receiver. Used for FPGA-to-FPGA links, loopback testing of the slave, and external peripherals.
- Takes one WIDTH-bit word per valid/ready handshake, shifts it out on MOSI, and samples MISO at the same time.
- Returns the received word on a valid/ready output port.
- Mode (CPOL/CPHA) and bit order (FSB) use the same encoding as the slave, so a paired instance interoperates with no glue logic.

Parameters:
- CPOL, 0: SCLK idle level (0 or 1).
- CPHA, 0: 0 = sample on leading edge, drive on trailing edge; 1 = drive on leading edge, sample on trailing edge.
- FSB, 1: first bit on the wire; 0 = LSB, 1 = MSB.
- WIDTH, 8: word width, 2..64.
- CLK_DIV, 4: clk cycles per SCLK half-period, >= 2. SCLK frequency = clk / (2*CLK_DIV).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- tx_valid  in  1  tx_data holds a word to send
- tx_ready  out  1  master can accept a word
- tx_data  in  WIDTH  word to transmit
- rx_valid  out  1  rx_data holds a received word
- rx_ready  in  1  consumer takes rx_data
- rx_data  out  WIDTH  last received word
- busy  out  1  high in every state except IDLE
- spi_sclk  out  1  SPI clock
- spi_ss_n  out  1  active-low slave select
- spi_mosi  out  1  master data out
- spi_miso  in  1  slave data in, sampled directly in the clk domain

Behaviour:
- Reset values (rst_n low at a clk edge): spi_sclk = CPOL, spi_ss_n = 1, spi_mosi = 0, rx_valid = 0, rx_data = 0, state = IDLE, all counters 0. Reset aborts any transfer mid-word; the partial word is discarded and no rx_valid is produced.
- Combinational outputs:
  - tx_ready = (state == IDLE) && !rx_valid. A received word is never overwritten.
  - busy = (state != IDLE).
- Divider:
  - div_cnt counts 0..CLK_DIV-1 in every state except IDLE.
  - tick = (div_cnt == CLK_DIV-1).
  - div_cnt clears on entry to SETUP.
- IDLE:
  - On tx_valid && tx_ready: latch tx_data into the shift register and go to SETUP.
  - At the same edge: spi_ss_n <= 0, and spi_mosi <= first bit (bit WIDTH-1 if FSB=1, bit 0 if FSB=0).
  - spi_ss_n therefore falls one cycle after the handshake cycle.
- SETUP, one half-period:
  - spi_sclk holds at CPOL.
  - On tick: go to XFER with edge counter e = 0.
- XFER, 2*WIDTH half-periods:
  - On each tick: toggle spi_sclk, then e increments.
  - Even e is a leading edge; odd e is a trailing edge.
  - CPHA=0: leading edge samples spi_miso into bit index e/2 (in wire order); trailing edge drives the next bit on spi_mosi, except at the last edge e = 2*WIDTH-1.
  - CPHA=1: leading edge drives the bit; for e = 0 this re-drives the first bit, so no change is visible. Trailing edge samples spi_miso.
  - Sampling and driving use the spi_miso value present at the tick cycle and update at that same clk edge.
  - After edge e = 2*WIDTH-1, spi_sclk is back at CPOL; go to HOLD.
- HOLD, one half-period:
  - spi_sclk = CPOL, spi_ss_n stays 0.
  - On tick: spi_ss_n <= 1, rx_data <= assembled word, rx_valid <= 1, go to GAP.
- GAP, one half-period:
  - spi_ss_n stays 1 (minimum deselect time).
  - On tick: go to IDLE.
- rx_valid clears on the cycle after rx_valid && rx_ready. rx_data holds its value until the next word completes.
- Bit order: receive bit mapping is identical to transmit. A loopback (MISO tied to MOSI) returns rx_data == tx_data for every CPOL/CPHA/FSB combination.
- Transfer timing, from handshake cycle to rx_valid high: 1 + (2*WIDTH + 2)*CLK_DIV cycles.
- Back-to-back throughput: one word every 1 + (2*WIDTH + 3)*CLK_DIV cycles, with rx_ready held high.
- tx_data changes while busy are ignored. tx_valid deasserting without a handshake is legal.

Test Plan:
- Loopback, CPOL=0 CPHA=0 FSB=1 WIDTH=8 CLK_DIV=4, send 0xA5 -> exactly 8 SCLK pulses of 8 clk period; MOSI sequence 1,0,1,0,0,1,0,1; rx_data = 0xA5; rx_valid high 1+18*4 = 73 cycles after the handshake.
- CPOL=1 CPHA=1 FSB=0, send 0x3C, MISO driven 0x96 LSB-first on trailing edges -> spi_sclk idles at 1; MOSI presents bits LSB-first 0,0,1,1,1,1,0,0; rx_data = 0x96.
- Backpressure: send 0x11 then offer 0x22 with rx_ready=0 -> tx_ready stays 0 after the first word; 0x11 held on rx_data; after one rx_ready cycle, 0x22 is accepted and returned.
- Reset mid-transfer: assert rst_n=0 after the 3rd SCLK edge -> next cycle spi_ss_n=1, spi_sclk=CPOL, rx_valid=0; a following transfer of 0xF0 completes correctly.
- CLK_DIV=2, WIDTH=16, send 0xBEEF in loopback -> SCLK period 4 clk; ss_n low exactly (2*16+2)*2 = 68 cycles; rx_data = 0xBEEF.
- Paired with spi_slave (same CPOL/CPHA/FSB/WIDTH, same clk, slave preloaded with 0x5A, CLK_DIV=8) -> slave asserts spi_valid with rx 0xC3 when master sends 0xC3; the master's next transfer returns 0x5A.
